// File: rtl/div_clk_monitor_if.sv
// Bundles the divided-clock input, the error clear and all measurement and
// status results of div_clk_monitor. The master side drives div_clk and clr_err.
// The slave side is the monitor, which returns the measurements.
// Handshake semantics: there is no back-pressure. meas_valid and err are
// single-cycle strobes, and the consumer must sample them in the cycle they are high.
// high_len, low_len and period_len stay valid until the next meas_valid.
interface div_clk_monitor_if #(
   parameter int CNT_W = 8
);
   logic               div_clk;
   logic               clr_err;
   logic [CNT_W-1:0]   high_len;
   logic [CNT_W-1:0]   low_len;
   logic [CNT_W:0]     period_len;
   logic               meas_valid;
   logic               lock;
   logic               err;
   logic               stuck;
   logic               err_sticky;
   logic [7:0]         err_count;

   modport master (
      output div_clk, clr_err,
      input  high_len, low_len, period_len, meas_valid, lock, err, stuck,
             err_sticky, err_count
   );

   modport slave (
      input  div_clk, clr_err,
      output high_len, low_len, period_len, meas_valid, lock, err, stuck,
             err_sticky, err_count
   );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures the high run, low run and period of a divided clock that is
// generated from clk_in. It checks each complete period against the expected
// shape and reports lock, a per-period strobe, and error and stuck status.
// fsm_state exposes the tracking FSM (0 SYNC, 1 HIGH, 2 LOW) for observation.
module div_clk_monitor #(
   parameter int HIGH_EXP = 2,
   parameter int LOW_EXP  = 3,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 8
) (
   input  logic                   clk_in,
   input  logic                   rst,
   div_clk_monitor_if.slave       mon,
   output logic [1:0]             fsm_state
);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int                 GW          = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0]      GOOD_MAX    = GW'(LOCK_CNT);
   localparam logic [CNT_W-1:0]   RUN_MAX     = '1;
   localparam logic [CNT_W-1:0]   RUN_MAX_M1  = RUN_MAX - CNT_W'(1);

   state_t             state_q, state_d;
   logic               d_q;
   logic               primed_q;
   logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0]   high_len_q, high_len_d;
   logic [CNT_W-1:0]   low_len_q, low_len_d;
   logic [CNT_W:0]     period_q, period_d;
   logic               meas_q, meas_d;
   logic               lock_q, lock_d;
   logic               err_q, err_d;
   logic               stuck_q, stuck_d;
   logic               sticky_q, sticky_d;
   logic [7:0]         errcnt_q, errcnt_d;
   logic [GW-1:0]      good_q, good_d;

   logic               rise;
   logic               fall;
   logic               stuck_hit;
   logic               good_period;

   // Edge detection on the sampled divided clock. The first cycle after reset
   // cannot report a rise, so a level that is already high at reset release
   // is treated as a partial phase.
   assign rise = primed_q & mon.div_clk & ~d_q;
   assign fall = d_q & ~mon.div_clk;

   // The run counter would reach its ceiling on this cycle while its phase is still running.
   assign stuck_hit = (run_cnt_q == RUN_MAX_M1) &&
                      (((state_q == HIGH) && !fall && mon.div_clk) ||
                       ((state_q == LOW)  && !rise && !mon.div_clk));

   assign good_period = (high_len_q == CNT_W'(HIGH_EXP)) &&
                        (run_cnt_q == CNT_W'(LOW_EXP));

   // State register for the phase-tracking FSM.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) state_q <= SYNC;
      else      state_q <= state_d;
   end

   // Next-state logic: follow the high and low phases, and drop back to SYNC on a stuck clock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC: if (rise) state_d = HIGH;
         HIGH: begin
            if (fall)           state_d = LOW;
            else if (stuck_hit) state_d = SYNC;
         end
         LOW: begin
            if (rise)           state_d = HIGH;
            else if (stuck_hit) state_d = SYNC;
         end
         default: state_d = SYNC;
      endcase
   end

   // Output/datapath next values: run counting, period capture, the lock
   // qualifier and error bookkeeping.
   always_comb begin
      run_cnt_d  = run_cnt_q;
      high_len_d = high_len_q;
      low_len_d  = low_len_q;
      period_d   = period_q;
      meas_d     = 1'b0;
      lock_d     = lock_q;
      err_d      = 1'b0;
      stuck_d    = stuck_q;
      good_d     = good_q;
      sticky_d   = sticky_q;
      errcnt_d   = errcnt_q;

      if (rise) stuck_d = 1'b0;

      case (state_q)
         SYNC: begin
            if (rise) run_cnt_d = CNT_W'(1);
         end
         HIGH: begin
            if (fall) begin
               high_len_d = run_cnt_q;
               run_cnt_d  = CNT_W'(1);
            end else if (mon.div_clk) begin
               run_cnt_d  = run_cnt_q + CNT_W'(1);
            end
         end
         LOW: begin
            if (rise) begin
               low_len_d = run_cnt_q;
               period_d  = {1'b0, high_len_q} + {1'b0, run_cnt_q};
               meas_d    = 1'b1;
               run_cnt_d = CNT_W'(1);
               if (good_period) begin
                  if (good_q < GOOD_MAX) good_d = good_q + GW'(1);
                  if (good_d == GOOD_MAX) lock_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  good_d = '0;
                  lock_d = 1'b0;
               end
            end else if (!mon.div_clk) begin
               run_cnt_d = run_cnt_q + CNT_W'(1);
            end
         end
         default: run_cnt_d = run_cnt_q;
      endcase

      // The counter lands on its ceiling and holds there. It does not wrap.
      if (stuck_hit) begin
         err_d   = 1'b1;
         stuck_d = 1'b1;
         lock_d  = 1'b0;
         good_d  = '0;
      end

      // A new error takes priority over a clear in the same cycle.
      if (err_d) begin
         sticky_d = 1'b1;
         if (mon.clr_err)            errcnt_d = 8'd1;
         else if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end else if (mon.clr_err) begin
         sticky_d = 1'b0;
         errcnt_d = 8'd0;
      end
   end

   // Registered datapath and outputs, cleared asynchronously by reset.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         d_q        <= 1'b0;
         primed_q   <= 1'b0;
         run_cnt_q  <= '0;
         high_len_q <= '0;
         low_len_q  <= '0;
         period_q   <= '0;
         meas_q     <= 1'b0;
         lock_q     <= 1'b0;
         err_q      <= 1'b0;
         stuck_q    <= 1'b0;
         good_q     <= '0;
         sticky_q   <= 1'b0;
         errcnt_q   <= 8'd0;
      end else begin
         d_q        <= mon.div_clk;
         primed_q   <= 1'b1;
         run_cnt_q  <= run_cnt_d;
         high_len_q <= high_len_d;
         low_len_q  <= low_len_d;
         period_q   <= period_d;
         meas_q     <= meas_d;
         lock_q     <= lock_d;
         err_q      <= err_d;
         stuck_q    <= stuck_d;
         good_q     <= good_d;
         sticky_q   <= sticky_d;
         errcnt_q   <= errcnt_d;
      end
   end

   assign mon.high_len   = high_len_q;
   assign mon.low_len    = low_len_q;
   assign mon.period_len = period_q;
   assign mon.meas_valid = meas_q;
   assign mon.lock       = lock_q;
   assign mon.err        = err_q;
   assign mon.stuck      = stuck_q;
   assign mon.err_sticky = sticky_q;
   assign mon.err_count  = errcnt_q;
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor in its default configuration: divide-by-5,
// with 2 cycles high and 3 cycles low. Each driven period pushes its expected
// measurement to exp_q. The monitor pops one entry on every meas_valid.
module tb_div_clk_monitor;
   localparam int CNT_W = 8;
   localparam int W     = 2 + CNT_W + CNT_W + CNT_W + 1;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b0;
   logic [1:0]  fsm_state;

   div_clk_monitor_if #(.CNT_W(CNT_W)) mon_if ();

   div_clk_monitor #(
      .HIGH_EXP (2),
      .LOW_EXP  (3),
      .LOCK_CNT (4),
      .CNT_W    (CNT_W)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .mon       (mon_if),
      .fsm_state (fsm_state)
   );

   // Clock and reset.
   always #5 clk_in = ~clk_in;

   int n_checks  = 0;
   int n_pass    = 0;
   int meas_seen = 0;
   int err_seen  = 0;
   int mdl_good  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_exp;
   logic [W-1:0] sb_got;

   // Scoreboard: compare every measurement against the oldest expected period.
   always @(posedge clk_in) begin
      #1;
      if (rst) begin
         if (mon_if.err) err_seen++;
         if (mon_if.meas_valid) begin
            meas_seen++;
            n_checks++;
            sb_got = {mon_if.err, mon_if.lock, mon_if.high_len, mon_if.low_len,
                      mon_if.period_len};
            if (exp_q.size() == 0) begin
               $display("FAIL meas_unexpected: got {err,lock,high,low,period}=%h, required no measurement",
                        sb_got);
            end else begin
               sb_exp = exp_q.pop_front();
               if (sb_got !== sb_exp)
                  $display("FAIL meas_compare: got {err,lock,high,low,period}=%h, required %h",
                           sb_got, sb_exp);
               else
                  n_pass++;
            end
         end
      end
   end

   // Driver: one div_clk period of h high and l low cycles. When the period
   // will complete, its expected measurement is pushed to exp_q.
   task automatic drive_period(input int h, input int l, input bit push, input bit clr_first);
      bit good;
      if (push) begin
         good = (h == 2) && (l == 3);
         if (good) begin
            if (mdl_good < 4) mdl_good++;
         end else begin
            mdl_good = 0;
         end
         exp_q.push_back({~good, (mdl_good == 4), CNT_W'(h), CNT_W'(l), (CNT_W+1)'(h + l)});
      end
      for (int i = 0; i < h; i++) begin
         @(negedge clk_in);
         mon_if.div_clk = 1'b1;
         mon_if.clr_err = clr_first && (i == 0);
      end
      for (int i = 0; i < l; i++) begin
         @(negedge clk_in);
         mon_if.div_clk = 1'b0;
         mon_if.clr_err = 1'b0;
      end
   endtask

   task automatic do_reset;
      @(negedge clk_in);
      rst            = 1'b0;
      mon_if.div_clk = 1'b0;
      mon_if.clr_err = 1'b0;
      exp_q.delete();
      mdl_good = 0;
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      mon_if.div_clk = 1'b0;
      mon_if.clr_err = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk_in);
      n_checks++;
      if ({mon_if.high_len, mon_if.low_len, mon_if.period_len} !== '0)
         $display("FAIL reset_lengths: got %h, required 0",
                  {mon_if.high_len, mon_if.low_len, mon_if.period_len});
      else n_pass++;
      n_checks++;
      if ({mon_if.meas_valid, mon_if.lock, mon_if.err, mon_if.stuck, mon_if.err_sticky} !== 5'b0)
         $display("FAIL reset_flags: got %b, required 00000",
                  {mon_if.meas_valid, mon_if.lock, mon_if.err, mon_if.stuck, mon_if.err_sticky});
      else n_pass++;
      n_checks++;
      if (mon_if.err_count !== 8'd0 || fsm_state !== 2'd0)
         $display("FAIL reset_count_state: got count=%0d state=%0d, required 0 and 0",
                  mon_if.err_count, fsm_state);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_default_stream;
      int m0, e0;
      m0 = meas_seen;
      e0 = err_seen;
      drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (mon_if.meas_valid !== 1'b0 || meas_seen != m0)
         $display("FAIL first_meas_early: got %0d measurements, required 0", meas_seen - m0);
      else n_pass++;
      repeat (5) drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (meas_seen - m0 != 5)
         $display("FAIL default_meas_count: got %0d, required 5", meas_seen - m0);
      else n_pass++;
      n_checks++;
      if (err_seen != e0 || mon_if.lock !== 1'b1)
         $display("FAIL default_lock: got errs=%0d lock=%b, required errs=0 lock=1",
                  err_seen - e0, mon_if.lock);
      else n_pass++;
   endtask

   task automatic test_bad_period;
      int e0;
      e0 = err_seen;
      drive_period(3, 2, 1'b1, 1'b0);
      repeat (5) drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (err_seen - e0 != 1)
         $display("FAIL bad_err_pulses: got %0d, required 1", err_seen - e0);
      else n_pass++;
      n_checks++;
      if (mon_if.err_count !== 8'd1 || mon_if.err_sticky !== 1'b1 || mon_if.lock !== 1'b1)
         $display("FAIL bad_status: got count=%0d sticky=%b lock=%b, required 1 1 1",
                  mon_if.err_count, mon_if.err_sticky, mon_if.lock);
      else n_pass++;
   endtask

   task automatic test_clr_collision;
      drive_period(3, 2, 1'b1, 1'b0);
      drive_period(2, 3, 1'b1, 1'b1);
      n_checks++;
      if (mon_if.err_sticky !== 1'b1 || mon_if.err_count !== 8'd1)
         $display("FAIL clr_collision: got sticky=%b count=%0d, required 1 1",
                  mon_if.err_sticky, mon_if.err_count);
      else n_pass++;
      drive_period(2, 3, 1'b1, 1'b1);
      n_checks++;
      if (mon_if.err_sticky !== 1'b0 || mon_if.err_count !== 8'd0)
         $display("FAIL clr_alone: got sticky=%b count=%0d, required 0 0",
                  mon_if.err_sticky, mon_if.err_count);
      else n_pass++;
   endtask

   task automatic test_stuck;
      int first_err, pulses, m0;
      first_err = -1;
      pulses    = 0;
      @(negedge clk_in);
      mon_if.div_clk = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk_in);
         if (mon_if.err) begin
            pulses++;
            if (first_err < 0) first_err = k;
         end
      end
      mdl_good = 0;
      n_checks++;
      if (first_err != 255 || pulses != 1)
         $display("FAIL stuck_timing: got first=%0d pulses=%0d, required 255 1", first_err, pulses);
      else n_pass++;
      n_checks++;
      if (mon_if.stuck !== 1'b1 || mon_if.lock !== 1'b0 || fsm_state !== 2'd0)
         $display("FAIL stuck_status: got stuck=%b lock=%b state=%0d, required 1 0 0",
                  mon_if.stuck, mon_if.lock, fsm_state);
      else n_pass++;
      n_checks++;
      if (mon_if.err_count !== 8'd1 || mon_if.err_sticky !== 1'b1)
         $display("FAIL stuck_count: got count=%0d sticky=%b, required 1 1",
                  mon_if.err_count, mon_if.err_sticky);
      else n_pass++;
      repeat (3) begin
         @(negedge clk_in);
         mon_if.div_clk = 1'b0;
      end
      n_checks++;
      if (mon_if.stuck !== 1'b1)
         $display("FAIL stuck_held_on_fall: got %b, required 1", mon_if.stuck);
      else n_pass++;
      m0 = meas_seen;
      drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (mon_if.stuck !== 1'b0)
         $display("FAIL stuck_clear: got %b, required 0", mon_if.stuck);
      else n_pass++;
      repeat (4) drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (meas_seen - m0 != 4 || mon_if.lock !== 1'b1)
         $display("FAIL stuck_resume: got meas=%0d lock=%b, required 4 1", meas_seen - m0, mon_if.lock);
      else n_pass++;
   endtask

   task automatic test_saturation;
      int m0;
      do_reset();
      m0 = meas_seen;
      repeat (261) drive_period(3, 2, 1'b1, 1'b0);
      n_checks++;
      if (meas_seen - m0 != 260 || mon_if.err_count !== 8'd255 || mon_if.err_sticky !== 1'b1)
         $display("FAIL err_count_saturate: got meas=%0d count=%0d sticky=%b, required 260 255 1",
                  meas_seen - m0, mon_if.err_count, mon_if.err_sticky);
      else n_pass++;
   endtask

   task automatic test_reset_mid_high;
      int m0;
      do_reset();
      repeat (2) drive_period(2, 3, 1'b1, 1'b0);
      @(negedge clk_in);
      mon_if.div_clk = 1'b1;
      @(negedge clk_in);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({mon_if.high_len, mon_if.low_len, mon_if.period_len, mon_if.meas_valid, mon_if.lock,
           mon_if.err, mon_if.stuck, mon_if.err_sticky, mon_if.err_count} !== '0 ||
          fsm_state !== 2'd0)
         $display("FAIL reset_async: got high=%0d low=%0d period=%0d state=%0d, required all 0",
                  mon_if.high_len, mon_if.low_len, mon_if.period_len, fsm_state);
      else n_pass++;
      exp_q.delete();
      mdl_good = 0;
      @(negedge clk_in);
      rst = 1'b1;
      m0 = meas_seen;
      repeat (3) @(negedge clk_in);
      repeat (3) begin
         @(negedge clk_in);
         mon_if.div_clk = 1'b0;
      end
      repeat (2) drive_period(2, 3, 1'b1, 1'b0);
      n_checks++;
      if (meas_seen - m0 != 1 || exp_q.size() != 1)
         $display("FAIL restart_partial: got meas=%0d pending=%0d, required 1 1",
                  meas_seen - m0, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_default_stream();
      test_bad_period();
      test_clr_collision();
      test_stuck();
      test_saturation();
      test_reset_mid_high();
      repeat (3) @(negedge clk_in);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Checks the divided clock produced by the odd clock divider. For the default configuration that is divide-by-5, high for 2 clk_in cycles and low for 3.
- Samples the divided clock synchronously on clk_in and measures the high run, low run and period in clk_in cycles.
- Compares each completed period against the expected shape.
- Reports lock, a per-period measurement strobe and error status to the clock-control/status logic downstream.

Parameters:
- HIGH_EXP, 2, expected high-phase length in clk_in cycles (≥1)
- LOW_EXP, 3, expected low-phase length in clk_in cycles (≥1)
- LOCK_CNT, 4, consecutive good periods required to assert lock (≥1)
- CNT_W, 8, width of the run-length counters and measurement outputs

Ports:
- clk_in  input  1  system clock; also clocks the divider under monitor
- rst  input  1  asynchronous, active-low reset
- div_clk  input  1  divided clock from the divider. It is generated from clk_in, so no synchronizer is used.
- clr_err  input  1  synchronous clear of err_sticky and err_count
- high_len  output  CNT_W  last measured high-run length
- low_len  output  CNT_W  last measured low-run length
- period_len  output  CNT_W+1  high_len+low_len of last period
- meas_valid  output  1  one-cycle strobe: new complete period measured
- lock  output  1  LOCK_CNT consecutive good periods seen, no error since
- err  output  1  one-cycle strobe: bad period or stuck clock
- stuck  output  1  sticky: run counter saturated; cleared on next rising edge of div_clk
- err_sticky  output  1  set on any err, held until clr_err or reset
- err_count  output  8  saturating count of err strobes (max 255)

Behaviour:
- Reset (rst=0, async): every output is 0. Internal state: d_q=0, run_cnt=0, good_cnt=0, FSM=SYNC.
- d_q samples div_clk every clk_in edge.
  - rise = div_clk & ~d_q
  - fall = ~div_clk & d_q
- All outputs are registered. An event detected in cycle t is visible at outputs from the edge ending cycle t.
- FSM SYNC: waits for rise. Any partial phase before the first rise is ignored.
  - On rise: run_cnt←1, go to HIGH.
- FSM HIGH: on ~fall with div_clk=1, run_cnt increments. On fall: high_len←run_cnt, run_cnt←1, go to LOW.
- FSM LOW: on ~rise with div_clk=0, run_cnt increments. On rise, the period completes:
  - low_len←run_cnt; period_len←high_len+low_len (zero-extended)
  - meas_valid←1 for one cycle
  - run_cnt←1, go to HIGH
- Period check, at completion:
  - Good when measured high==HIGH_EXP and low==LOW_EXP. Otherwise bad.
  - Good: good_cnt increments, saturating at LOCK_CNT. lock←1 when good_cnt reaches LOCK_CNT.
  - Bad: err pulse, good_cnt←0, lock←0.
  - lock rises in the same cycle as the meas_valid of the LOCK_CNT-th good period.
- Stuck detection: if run_cnt reaches 2^CNT_W−1 in HIGH or LOW:
  - err pulse, stuck←1, lock←0, good_cnt←0
  - FSM→SYNC; run_cnt holds, no wrap-around
  - stuck clears on the next rise.
- err_sticky/err_count:
  - Set/increment on every err; err_count saturates at 255.
  - clr_err clears both.
  - clr_err in the same cycle as err: error wins, err_sticky=1, err_count=1.
- Default stream (2 high / 3 low) yields high_len=2, low_len=3, period_len=5 every 5 clk_in cycles. meas_valid is periodic with period 5.
- Reset asserted mid-period: immediate clear of all outputs. After release, the FSM restarts in SYNC; no measurement is produced until a full high+low period is observed.

Test Plan:
- Default divider stream, 2 high / 3 low, from reset:
  - First meas_valid appears only after one full period following the first rise.
  - high_len=2, low_len=3, period_len=5.
  - lock=1 at the 4th meas_valid; err never asserted.
- Locked, then inject one period of 3 high / 2 low:
  - err pulses once with that meas_valid; lock→0; err_count=1; err_sticky=1.
  - lock returns after 4 further good periods.
- Hold div_clk=1 for 300 cycles with CNT_W=8:
  - err and stuck assert at run_cnt=255; run_cnt does not wrap; lock=0.
  - Resume the good stream: stuck clears at the next rise; measurements resume.
- Drive clr_err in the same cycle as an err pulse → err_sticky=1, err_count=1.
  - clr_err alone later → both 0.
- Force 260 bad periods → err_count saturates at 255.
- Assert rst mid-high phase → all outputs 0 immediately.
  - After release, starting div_clk high (partial phase): first meas_valid comes only after the next complete rise-to-rise period.
